update_scheduler: RTL and testbench
===================================

Name: update_scheduler

Overview:
- Shares one serial 74HC595-style output chain between two 8-bit setter channels (data/update pairs from the key-driven value setters).
- Detects each channel's update pulse, captures its byte, and arbitrates round-robin between pending channels.
- Shifts a 16-bit frame (select byte + data byte) out MSB-first, then pulses the storage latch.
- Sits between the setters and the board's shift-register display/LED chain.

Parameters:
- CLK_DIV, 4, clk cycles per sh_clk half-period; legal range 1..255.
- DATA_W, 8, data byte width; fixed at 8 in this revision.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data0  in  8  channel 0 value.
- update0  in  1  channel 0 update request; level pulse, may stay high for several cycles.
- data1  in  8  channel 1 value.
- update1  in  1  channel 1 update request; same form as update0.
- sh_clk  out  1  shift clock to the chain.
- sh_data  out  1  serial data; changes only while sh_clk is low.
- sh_latch  out  1  storage-register latch pulse.
- busy  out  1  high from frame start until the latch pulse ends.
- grant  out  2  one-hot channel being transmitted; 00 when idle.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (sync, high): all outputs 0. Pending flags cleared, captured bytes 0, state IDLE, rr pointer = ch0 preferred, update*_prev = 0. Reset mid-frame aborts the frame immediately; no latch pulse is issued.
- Capture: a rising edge (updateN = 1 and prev = 0 at a clk edge) sets pendN and loads capN <= dataN on the same edge. High levels after the edge are ignored.
- A new edge while pendN is already set overwrites capN; pendN stays set (coalesce, last value wins).
- A new edge on the channel currently being shifted sets pendN with the new byte. The in-flight frame continues with its snapshot byte; the channel is resent later.
- Arbitration (IDLE only):
  - One pending channel: grant it.
  - Both pending: grant the channel the rr pointer prefers, then point rr at the other channel.
  - Granting clears that channel's pend and copies capN into the frame shift register on the same edge, unless a capture edge for that channel coincides, in which case pend stays set.
- Frame: bits[15:8] = select byte (8'h01 for ch0, 8'h02 for ch1); bits[7:0] = captured data. Sent MSB first.
- States:
  - IDLE -> SHIFT_LO on grant. busy = 1, grant set, sh_data = frame[15], sh_clk = 0, divider = 0.
  - SHIFT_LO: hold CLK_DIV cycles, then sh_clk <= 1 and go to SHIFT_HI.
  - SHIFT_HI: hold CLK_DIV cycles, then sh_clk <= 0.
    - Not last bit: shift the next bit onto sh_data and go to SHIFT_LO.
    - After bit 0: go to LATCH.
  - LATCH: sh_latch = 1 for CLK_DIV cycles, then sh_latch <= 0, busy <= 0, grant <= 00, done = 1 for one cycle, go to IDLE.
- Latency: capture edge in IDLE -> busy high 1 cycle later (pend set, then grant). Frame length = 32*CLK_DIV + CLK_DIV cycles. Back-to-back frames are separated by exactly one IDLE cycle.
- Divider counter is 8 bits; bit counter is 4 bits and counts 15 down to 0. No wrap beyond bit 0.

Decomposition:
- Shared package: state encoding (IDLE, SHIFT_LO, SHIFT_HI, LATCH), FRAME_W = 16, SEL_CH0 = 8'h01, SEL_CH1 = 8'h02.
- One sub-module, update_capture: edge detect, pend flag and byte capture for one channel, with a clear input. Instantiated twice.

Test Plan:
- Reset, CLK_DIV=2; update0 pulse 8 cycles with data0=8'hA5 -> busy after 1 cycle, sh_data sequence 0x01A5 MSB-first sampled on sh_clk rise, sh_latch high 2 cycles, done at cycle 66 after start, grant = 01 throughout.
- update0 and update1 rise on the same cycle (0x11, 0x22) -> frame 0x0111 then 0x0222, one IDLE cycle between them. Next simultaneous pair -> ch1 first (rr rotated).
- Two update0 edges (0x10, then 0x20) while ch1 frame is in flight -> only one ch0 frame is sent, carrying 0x20.
- update0 edge with 0x33 during its own frame of 0x44 -> 0x0144 completes, then 0x0133 is sent.
- Reset asserted during the 10th bit -> next cycle all outputs 0, no latch pulse, no pending frame sent afterwards.
- CLK_DIV=1 -> frame length 33 cycles, sh_clk toggles every cycle, data correct.

Source files
------------

// File: rtl/update_scheduler_pkg.sv
// Shared types and constants for the two-channel serial update scheduler.
package update_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

  localparam int         FRAME_W = 16;
  localparam logic [7:0] SEL_CH0 = 8'h01;
  localparam logic [7:0] SEL_CH1 = 8'h02;

  function automatic logic [FRAME_W-1:0] make_frame(input logic ch, input logic [7:0] data);
    return {(ch ? SEL_CH1 : SEL_CH0), data};
  endfunction

endpackage

// File: rtl/update_scheduler_capture.sv
// One setter channel: rising-edge detect on update, pending flag and byte capture.
module update_capture #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic              pend,
  output logic [DATA_W-1:0] cap
);

  logic              prev_q, prev_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              edge_det;

  assign edge_det = update & ~prev_q;

  // A fresh edge wins over a grant clear so the new byte is never lost.
  always_comb begin
    prev_d = update;
    pend_d = pend_q;
    cap_d  = cap_q;
    if (edge_det) begin
      pend_d = 1'b1;
      cap_d  = data;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      cap_q  <= '0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      cap_q  <= cap_d;
    end
  end

  assign pend = pend_q;
  assign cap  = cap_q;

endmodule

// File: rtl/update_scheduler.sv
// Round-robin sharing of one 74HC595-style chain between two setter channels.
//   state       | meaning
//   ST_IDLE     | waiting for a pending channel, arbitrates
//   ST_SHIFT_LO | sh_clk low, current bit on sh_data
//   ST_SHIFT_HI | sh_clk high, chain samples the bit
//   ST_LATCH    | sh_latch high, frame being stored
module update_scheduler
  import update_scheduler_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data0,
  input  logic              update0,
  input  logic [DATA_W-1:0] data1,
  input  logic              update1,
  output logic              sh_clk,
  output logic              sh_data,
  output logic              sh_latch,
  output logic              busy,
  output logic [1:0]        grant,
  output logic              done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic              pend0, pend1, clr0, clr1;
  logic [DATA_W-1:0] cap0, cap1;
  logic [1:0]        pend;

  update_capture #(.DATA_W(DATA_W)) u_cap0 (
    .clk(clk), .reset(reset), .update(update0), .data(data0),
    .clr(clr0), .pend(pend0), .cap(cap0)
  );

  update_capture #(.DATA_W(DATA_W)) u_cap1 (
    .clk(clk), .reset(reset), .update(update1), .data(data1),
    .clr(clr1), .pend(pend1), .cap(cap1)
  );

  assign pend = {pend1, pend0};

  state_e             state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic               rr_q, rr_d;
  logic               sh_clk_q, sh_clk_d;
  logic               sh_data_q, sh_data_d;
  logic               sh_latch_q, sh_latch_d;
  logic               busy_q, busy_d;
  logic [1:0]         grant_q, grant_d;
  logic               done_q, done_d;
  logic               div_term, pick;
  logic [FRAME_W-1:0] frame;

  assign div_term = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rr_d       = rr_q;
    sh_clk_d   = sh_clk_q;
    sh_data_d  = sh_data_q;
    sh_latch_d = sh_latch_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
    done_d     = 1'b0;
    clr0       = 1'b0;
    clr1       = 1'b0;
    pick       = 1'b0;
    frame      = '0;
    case (state_q)
      ST_IDLE: begin
        if (pend != 2'b00) begin
          // rr_q = 0 prefers ch0; it only rotates when both channels compete.
          pick = (pend == 2'b11) ? rr_q : pend[1];
          if (pend == 2'b11) rr_d = ~pick;
          clr0      = ~pick;
          clr1      = pick;
          frame     = make_frame(pick, pick ? cap1 : cap0);
          shift_d   = frame[FRAME_W-2:0];
          sh_data_d = frame[FRAME_W-1];
          sh_clk_d  = 1'b0;
          div_d     = '0;
          bit_d     = 4'd15;
          busy_d    = 1'b1;
          grant_d   = pick ? 2'b10 : 2'b01;
          state_d   = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (div_term) begin
          div_d    = '0;
          sh_clk_d = 1'b1;
          state_d  = ST_SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_term) begin
          div_d    = '0;
          sh_clk_d = 1'b0;
          if (bit_q == 4'd0) begin
            sh_latch_d = 1'b1;
            state_d    = ST_LATCH;
          end else begin
            sh_data_d = shift_q[FRAME_W-2];
            shift_d   = {shift_q[FRAME_W-3:0], 1'b0};
            bit_d     = bit_q - 4'd1;
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_LATCH: begin
        if (div_term) begin
          div_d      = '0;
          sh_latch_d = 1'b0;
          busy_d     = 1'b0;
          grant_d    = 2'b00;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rr_q       <= 1'b0;
      sh_clk_q   <= 1'b0;
      sh_data_q  <= 1'b0;
      sh_latch_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rr_q       <= rr_d;
      sh_clk_q   <= sh_clk_d;
      sh_data_q  <= sh_data_d;
      sh_latch_q <= sh_latch_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
    end
  end

  assign sh_clk   = sh_clk_q;
  assign sh_data  = sh_data_q;
  assign sh_latch = sh_latch_q;
  assign busy     = busy_q;
  assign grant    = grant_q;
  assign done     = done_q;

endmodule

// File: tb/tb_update_scheduler.sv
// Scoreboard bench: two schedulers (CLK_DIV=2 and CLK_DIV=1) against a frame-level reference model.
module tb_update_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] upd [2];
  logic [7:0] dat [2][2];
  logic       sck [2], sdat [2], slat [2], bsy [2], dn [2];
  logic [1:0] gnt [2];

  update_scheduler #(.CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset),
    .data0(dat[0][0]), .update0(upd[0][0]), .data1(dat[0][1]), .update1(upd[0][1]),
    .sh_clk(sck[0]), .sh_data(sdat[0]), .sh_latch(slat[0]),
    .busy(bsy[0]), .grant(gnt[0]), .done(dn[0])
  );

  update_scheduler #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .data0(dat[1][0]), .update0(upd[1][0]), .data1(dat[1][1]), .update1(upd[1][1]),
    .sh_clk(sck[1]), .sh_data(sdat[1]), .sh_latch(slat[1]),
    .busy(bsy[1]), .grant(gnt[1]), .done(dn[1])
  );

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  typedef struct {
    int          dut;
    logic [15:0] frame;
    logic [1:0]  grant;
    int          start;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic rst_seen = 1'b0;

  // Reference model: per channel a pending flag and last captured byte; the
  // shared chain is simply "busy for 33*CLK_DIV cycles" after each grant.
  logic [1:0] m_pend [2];
  logic [7:0] m_cap  [2][2];
  logic [1:0] m_prev [2];
  logic       m_rr   [2];
  int         m_busy [2];
  int         m_ch;
  exp_t       m_e;

  always @(posedge clk) begin
    cyc++;
    rst_seen = reset;
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        m_pend[g] = 2'b00;
        m_prev[g] = 2'b00;
        m_cap[g][0] = 8'h00;
        m_cap[g][1] = 8'h00;
        m_rr[g] = 1'b0;
        m_busy[g] = 0;
        for (int i = sbq.size() - 1; i >= 0; i--)
          if (sbq[i].dut == g) sbq.delete(i);
      end else begin
        if (m_busy[g] > 0) begin
          m_busy[g]--;
        end else if (m_pend[g] != 2'b00) begin
          if (m_pend[g] == 2'b11) begin
            m_ch = m_rr[g] ? 1 : 0;
            m_rr[g] = (m_ch == 0);
          end else begin
            m_ch = m_pend[g][0] ? 0 : 1;
          end
          m_e.dut   = g;
          m_e.frame = {((m_ch == 0) ? 8'h01 : 8'h02), m_cap[g][m_ch]};
          m_e.grant = (m_ch == 0) ? 2'b01 : 2'b10;
          m_e.start = cyc;
          sbq.push_back(m_e);
          m_pend[g][m_ch] = 1'b0;
          m_busy[g] = 33 * div_of(g);
        end
        for (int c = 0; c < 2; c++) begin
          if (upd[g][c] && !m_prev[g][c]) begin
            m_pend[g][c] = 1'b1;
            m_cap[g][c]  = dat[g][c];
          end
        end
        m_prev[g] = upd[g];
      end
    end
  end

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: actual=%0h required=%0h", name, g, cyc, act, exp);
    end
  endtask

  // Monitor: rebuilds each frame from the pins and compares it with the queue.
  logic        act  [2] = '{1'b0, 1'b0};
  logic [15:0] bits [2];
  int          nbits [2], blen [2], llen [2], st [2];
  logic [1:0]  gst  [2];
  logic        psck [2] = '{1'b0, 1'b0};
  logic        psdat [2] = '{1'b0, 1'b0};
  logic        end_req  = 1'b0;
  logic        end_done = 1'b0;
  int          idx;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_seen)
        check("reset_outputs", g, 32'({sck[g], sdat[g], slat[g], bsy[g], gnt[g], dn[g]}), 32'd0);
      if (act[g]) begin
        if (dn[g]) begin
          idx = -1;
          for (int i = 0; i < sbq.size(); i++)
            if (idx < 0 && sbq[i].dut == g) idx = i;
          check("frame_expected", g, 32'(idx >= 0), 32'd1);
          if (idx >= 0) begin
            check("frame_bits", g, 32'(bits[g]), 32'(sbq[idx].frame));
            check("bit_count", g, 32'(nbits[g]), 32'd16);
            check("grant", g, 32'(gst[g]), 32'(sbq[idx].grant));
            check("start_cycle", g, 32'(st[g]), 32'(sbq[idx].start));
            check("busy_length", g, 32'(blen[g]), 32'(33 * div_of(g)));
            check("latch_length", g, 32'(llen[g]), 32'(div_of(g)));
            check("idle_after_done", g, 32'({bsy[g], gnt[g]}), 32'd0);
            sbq.delete(idx);
          end
          act[g] = 1'b0;
        end else if (!bsy[g]) begin
          check("abort_no_latch", g, 32'(llen[g]), 32'd0);
          act[g] = 1'b0;
        end else begin
          blen[g]++;
          if (slat[g]) llen[g]++;
          if (sck[g] && !psck[g]) begin
            bits[g] = {bits[g][14:0], sdat[g]};
            nbits[g]++;
          end
          if (sck[g] && psck[g])
            check("sh_data_stable_hi", g, 32'(sdat[g]), 32'(psdat[g]));
          check("grant_hold", g, 32'(gnt[g]), 32'(gst[g]));
        end
      end else begin
        check("done_outside_frame", g, 32'(dn[g]), 32'd0);
        if (bsy[g]) begin
          act[g]   = 1'b1;
          blen[g]  = 1;
          llen[g]  = slat[g] ? 1 : 0;
          nbits[g] = 0;
          bits[g]  = 16'h0000;
          gst[g]   = gnt[g];
          st[g]    = cyc;
          check("start_sh_clk_low", g, 32'(sck[g]), 32'd0);
        end
      end
      psck[g]  = sck[g];
      psdat[g] = sdat[g];
    end
    if (end_req && !end_done) begin
      check("scoreboard_drained", 0, 32'(sbq.size()), 32'd0);
      end_done = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int g, input int ch, input logic [7:0] d, input int len);
    dat[g][ch] = d;
    upd[g][ch] = 1'b1;
    idle(len);
    upd[g][ch] = 1'b0;
  endtask

  task automatic pair(input int g, input logic [7:0] d0, input logic [7:0] d1);
    dat[g][0] = d0;
    dat[g][1] = d1;
    upd[g] = 2'b11;
    idle(3);
    upd[g] = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      upd[g] = 2'b00;
      dat[g][0] = 8'h00;
      dat[g][1] = 8'h00;
    end
    idle(3);
    reset = 1'b0;
    idle(2);

    pulse(0, 0, 8'hA5, 8);
    idle(80);
    pair(0, 8'h11, 8'h22);
    idle(150);
    pair(0, 8'h55, 8'h66);
    idle(150);

    pulse(0, 1, 8'h77, 1);
    idle(5);
    pulse(0, 0, 8'h10, 2);
    idle(3);
    pulse(0, 0, 8'h20, 2);
    idle(200);

    pulse(0, 0, 8'h44, 1);
    idle(10);
    pulse(0, 0, 8'h33, 1);
    idle(200);

    pulse(0, 0, 8'hC3, 1);
    idle(37);
    pulse(0, 1, 8'h5A, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(200);

    pulse(1, 0, 8'hE7, 2);
    idle(60);
    pair(1, 8'h3C, 8'hC3);
    idle(100);

    for (int k = 0; k < 3000; k++) begin
      for (int g = 0; g < 2; g++) begin
        for (int c = 0; c < 2; c++) begin
          if (upd[g][c]) begin
            if ($urandom_range(0, 1) == 1) upd[g][c] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) begin
            dat[g][c] = 8'($urandom_range(0, 255));
            upd[g][c] = 1'b1;
          end
        end
      end
      idle(1);
    end
    upd[0] = 2'b00;
    upd[1] = 2'b00;
    idle(300);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(negedge clk);
    if (!end_done) begin
      $display("FAIL end_handshake: actual=0 required=1");
      $fatal(1, "monitor did not respond");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
